btn_flag_ctrl: RTL and testbench

BTN_FLAG_CTRL -- requirements
Module: btn_flag_ctrl

---
 rtl/btn_flag_ctrl_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 108 ++++++++++
 rtl/btn_flag_ctrl.sv | 60 ++++++
 tb/tb_btn_flag_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_flag_ctrl_pkg.sv
// Shared constants for the button/flag controller: channel count, default
// debounce length and the debounce state encoding.
package btn_flag_ctrl_pkg;

  localparam int NCH_DEF     = 7;
  localparam int DEB_CNT_DEF = 1000000;

  typedef logic [1:0] deb_state_t;

  localparam deb_state_t ST_IDLE       = 2'd0;
  localparam deb_state_t ST_PRESS_WAIT = 2'd1;
  localparam deb_state_t ST_HELD       = 2'd2;
  localparam deb_state_t ST_REL_WAIT   = 2'd3;

  function automatic int cnt_width(input int n);
    if (n < 1) begin
      return 1;
    end else begin
      return $clog2(n + 1);
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, debounce FSM with a saturating
// stability counter, and a one-cycle registered press strobe.
module btn_debounce
  import btn_flag_ctrl_pkg::*;
#(
  parameter int DEB_CNT = DEB_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic accept,
  output logic press_pulse
);

  localparam int CW = cnt_width(DEB_CNT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

  logic           sync1_r;
  logic           sync2_r;
  deb_state_t     state_r;
  deb_state_t     state_nx_s;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_nx_s;
  logic           accept_s;
  logic           pulse_r;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v >= CNT_MAX) begin
      return CNT_MAX;
    end else begin
      return v + CW'(1);
    end
  endfunction

  // Next-state and counter logic; the sample in IDLE counts as the first stable one.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    accept_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nx_s = '0;
        if (sync2_r) begin
          state_nx_s = ST_PRESS_WAIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync2_r) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = '0;
        end else if (cnt_r >= CNT_LAST) begin
          state_nx_s = ST_HELD;
          cnt_nx_s   = '0;
          accept_s   = 1'b1;
        end else begin
          cnt_nx_s   = sat_inc(cnt_r);
        end
      end
      ST_HELD: begin
        cnt_nx_s = '0;
        if (!sync2_r) begin
          state_nx_s = ST_REL_WAIT;
        end else begin
          state_nx_s = ST_HELD;
        end
      end
      ST_REL_WAIT: begin
        if (sync2_r) begin
          state_nx_s = ST_HELD;
          cnt_nx_s   = '0;
        end else if (cnt_r >= CNT_LAST) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = '0;
        end else begin
          cnt_nx_s   = sat_inc(cnt_r);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = '0;
      end
    endcase
  end

  // Synchronizer, FSM state, counter and press strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      pulse_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      pulse_r <= accept_s;
    end
  end

  assign accept      = accept_s;
  assign press_pulse = pulse_r;

endmodule

// File: rtl/btn_flag_ctrl.sv
// Per-channel run flags for the code sequencers: a press freezes its channel,
// and once every channel is frozen the next press restarts all of them.
module btn_flag_ctrl
  import btn_flag_ctrl_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int DEB_CNT = DEB_CNT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] BTN,
  output logic [NCH-1:0] flag,
  output logic [NCH-1:0] press_pulse,
  output logic           done
);

  logic [NCH-1:0] accept_s;
  logic [NCH-1:0] flag_r;
  logic [NCH-1:0] flag_nx_s;
  logic           done_r;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .clk         (clk),
      .rst         (rst),
      .btn         (BTN[g]),
      .accept      (accept_s[g]),
      .press_pulse (press_pulse[g])
    );
  end

  // Accept is the same-edge version of press_pulse, so flag moves with the strobe.
  always_comb begin
    flag_nx_s = flag_r;
    if (accept_s != '0) begin
      if (done_r) begin
        flag_nx_s = '1;
      end else begin
        flag_nx_s = flag_r & ~accept_s;
      end
    end else begin
      flag_nx_s = flag_r;
    end
  end

  // Flag and done registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_r <= '1;
      done_r <= 1'b0;
    end else begin
      flag_r <= flag_nx_s;
      done_r <= (flag_nx_s == '0);
    end
  end

  assign flag = flag_r;
  assign done = done_r;

endmodule

// File: tb/tb_btn_flag_ctrl.sv
// Self-checking bench for btn_flag_ctrl with DEB_CNT=4: directed scenarios plus
// randomized buttons compared against a run-length debounce model.
module tb_btn_flag_ctrl;

  localparam int NCH = 7;
  localparam int DEB = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] BTN = '0;
  logic [NCH-1:0] flag;
  logic [NCH-1:0] press_pulse;
  logic           done;

  int checks = 0;
  int errors = 0;

  btn_flag_ctrl #(.NCH(NCH), .DEB_CNT(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .BTN         (BTN),
    .flag        (flag),
    .press_pulse (press_pulse),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Reference model: accepted level flips after DEB+1 consecutive synchronized
  // samples that disagree with it; rising flips are presses.
  logic [NCH-1:0] m_s1, m_s2, m_lvl, m_acc, m_flag, m_flag_nx, m_pulse;
  logic           m_done;
  int             m_run [NCH];

  always_comb begin
    m_acc = '0;
    for (int i = 0; i < NCH; i++)
      if (m_s2[i] != m_lvl[i] && m_run[i] == DEB && !m_lvl[i]) m_acc[i] = 1'b1;
    m_flag_nx = m_flag;
    if (m_acc != '0) m_flag_nx = m_done ? {NCH{1'b1}} : (m_flag & ~m_acc);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_pulse <= '0;
      m_flag <= {NCH{1'b1}}; m_done <= 1'b0;
      for (int i = 0; i < NCH; i++) m_run[i] <= 0;
    end else begin
      m_s1 <= BTN;
      m_s2 <= m_s1;
      for (int i = 0; i < NCH; i++) begin
        if (m_s2[i] == m_lvl[i]) m_run[i] <= 0;
        else if (m_run[i] == DEB) begin
          m_lvl[i] <= m_s2[i];
          m_run[i] <= 0;
        end else m_run[i] <= m_run[i] + 1;
      end
      m_pulse <= m_acc;
      m_flag  <= m_flag_nx;
      m_done  <= (m_flag_nx == '0);
    end
  end

  // Presses a channel and returns the edge index (0 = sampling edge) of its strobe, -1 on timeout.
  task automatic press_wait(input int ch, output int lat);
    @(negedge clk);
    BTN[ch] = 1'b1;
    lat = -1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (press_pulse[ch]) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic release_all();
    @(negedge clk);
    BTN = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    BTN = '0;
    repeat (3) @(negedge clk);
    checks++; if (flag !== 7'h7F) begin errors++; $display("FAIL reset_flag got %h want 7f", flag); end
    checks++; if (press_pulse !== 7'h00) begin errors++; $display("FAIL reset_pulse got %h want 00", press_pulse); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (flag !== 7'h7F || done !== 1'b0) begin errors++; $display("FAIL post_reset got flag=%h done=%b want 7f 0", flag, done); end
  endtask

  task automatic test_clean_press();
    int lat;
    press_wait(3, lat);
    checks++; if (lat != 6) begin errors++; $display("FAIL clean_latency got %0d want 6", lat); end
    checks++; if (flag !== 7'h77) begin errors++; $display("FAIL clean_flag got %h want 77", flag); end
    @(posedge clk); #1;
    checks++; if (press_pulse[3] !== 1'b0) begin errors++; $display("FAIL clean_one_cycle got %b want 0", press_pulse[3]); end
    release_all();
  endtask

  task automatic test_bounce();
    bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int cnt = 0;
    int at = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      BTN[0] = (k < 5) ? pat[k] : 1'b1;
      @(posedge clk); #1;
      if (press_pulse[0]) begin
        cnt++;
        at = k;
      end
    end
    checks++; if (cnt != 1) begin errors++; $display("FAIL bounce_count got %0d want 1", cnt); end
    checks++; if (at != 11) begin errors++; $display("FAIL bounce_edge got %0d want 11", at); end
    checks++; if (flag !== 7'h76) begin errors++; $display("FAIL bounce_flag got %h want 76", flag); end
    release_all();
  endtask

  task automatic test_all_channels();
    logic [NCH-1:0] exp_flag = 7'h76;
    int lat;
    for (int i = 0; i < NCH; i++) begin
      exp_flag[i] = 1'b0;
      press_wait(i, lat);
      checks++; if (lat != 6) begin errors++; $display("FAIL seq_latency ch%0d got %0d want 6", i, lat); end
      checks++; if (flag !== exp_flag || done !== (exp_flag == '0)) begin
        errors++; $display("FAIL seq_flag ch%0d got %h/%b want %h/%b", i, flag, done, exp_flag, (exp_flag == '0));
      end
      release_all();
    end
    press_wait(5, lat);
    checks++; if (lat != 6) begin errors++; $display("FAIL restart_latency got %0d want 6", lat); end
    checks++; if (flag !== 7'h7F || done !== 1'b0) begin errors++; $display("FAIL restart got %h/%b want 7f/0", flag, done); end
    release_all();
  endtask

  task automatic test_simultaneous();
    int e1 = -1;
    int e2 = -1;
    logic [NCH-1:0] f_at = '0;
    @(negedge clk);
    BTN[1] = 1'b1;
    BTN[2] = 1'b1;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (press_pulse[1] && e1 < 0) begin e1 = e; f_at = flag; end
      if (press_pulse[2] && e2 < 0) e2 = e;
    end
    checks++; if (e1 != 6 || e2 != 6) begin errors++; $display("FAIL simul_edges got %0d,%0d want 6,6", e1, e2); end
    checks++; if (f_at !== 7'h79) begin errors++; $display("FAIL simul_flag got %h want 79", f_at); end
    release_all();
  endtask

  task automatic test_long_hold();
    int lat;
    int extra = 0;
    press_wait(4, lat);
    checks++; if (lat != 6 || flag !== 7'h69) begin errors++; $display("FAIL hold_first got lat=%0d flag=%h want 6 69", lat, flag); end
    repeat (100) begin
      @(posedge clk); #1;
      if (press_pulse[4]) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL hold_extra got %0d want 0", extra); end
    release_all();
    press_wait(4, lat);
    checks++; if (lat != 6) begin errors++; $display("FAIL hold_second got %0d want 6", lat); end
    checks++; if (flag !== 7'h69 || done !== 1'b0) begin errors++; $display("FAIL hold_frozen got %h/%b want 69/0", flag, done); end
    release_all();
  endtask

  task automatic test_reset_mid();
    int at = -1;
    logic [NCH-1:0] f_at = '0;
    @(negedge clk);
    BTN[6] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (flag !== 7'h7F || press_pulse !== 7'h00 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_state got %h/%h/%b want 7f/00/0", flag, press_pulse, done);
    end
    rst = 1'b1;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (press_pulse[6] && at < 0) begin at = e; f_at = flag; end
    end
    checks++; if (at != 6) begin errors++; $display("FAIL midrst_edge got %0d want 6", at); end
    checks++; if (f_at !== 7'h3F) begin errors++; $display("FAIL midrst_flag got %h want 3f", f_at); end
    release_all();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 19) == 0) BTN[i] = ~BTN[i];
      @(posedge clk); #1;
      checks++; if (flag !== m_flag) begin errors++; if (errors < 20) $display("FAIL rand_flag cyc %0d got %h want %h", c, flag, m_flag); end
      checks++; if (press_pulse !== m_pulse) begin errors++; if (errors < 20) $display("FAIL rand_pulse cyc %0d got %h want %h", c, press_pulse, m_pulse); end
      checks++; if (done !== m_done) begin errors++; if (errors < 20) $display("FAIL rand_done cyc %0d got %b want %b", c, done, m_done); end
    end
    release_all();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_all_channels();
    test_simultaneous();
    test_long_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
